// File: rtl/ysyx_220053_scoreboard.sv
// ysyx_220053_scoreboard: hazard detection, per-register in-flight write
// counters and operand forwarding for the ID stage of an in-order pipeline.
// Stage 0 is the youngest forwarding stage (EX). A source stalls when its
// youngest in-window producer is not final yet. It also stalls when no stage
// in the window produces it but writes to it are still in flight further down.
// Optional feature macro: YSYX_220053_SB_PERF_EN adds a saturating 32-bit
// stall cycle counter output (stall_cnt).
module ysyx_220053_scoreboard #(
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int XLEN = 64,
    parameter int NSTG = 3,
    parameter int CNTW = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic                 id_fire,
    input  logic [AW-1:0]        id_rs1,
    input  logic [AW-1:0]        id_rs2,
    input  logic                 id_rs1_use,
    input  logic                 id_rs2_use,
    input  logic                 id_wen,
    input  logic [AW-1:0]        id_rd,
    input  logic [NSTG-1:0]      stg_valid,
    input  logic [NSTG-1:0]      stg_wen,
    input  logic [NSTG-1:0]      stg_rdy,
    input  logic [NSTG*AW-1:0]   stg_rd,
    input  logic [NSTG*XLEN-1:0] stg_data,
    input  logic                 retire,
    input  logic [AW-1:0]        retire_rd,
    input  logic                 flush,
    output logic                 stall,
    output logic                 fwd1_en,
    output logic                 fwd2_en,
    output logic [XLEN-1:0]      fwd1_data,
    output logic [XLEN-1:0]      fwd2_data,
    output logic [NREG-1:0]      busy_map,
    output logic                 sb_err
`ifdef YSYX_220053_SB_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [CNTW-1:0] CNT_MAX = '1;

    logic [CNTW-1:0] cnt_reg  [NREG];
    logic [CNTW-1:0] cnt_next [NREG];
    logic            sb_err_reg;
    logic            sb_err_next;

    // Both sources share one resolver: index 0 is rs1, index 1 is rs2.
    logic [2*AW-1:0]   src_idx;
    logic [1:0]        src_use;
    logic [1:0]        src_fwd;
    logic [1:0]        src_stall;
    logic [2*XLEN-1:0] src_data;

    assign src_idx = {id_rs2, id_rs1};
    assign src_use = {id_rs2_use, id_rs1_use};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            logic            hit;
            logic            hit_rdy;
            logic [XLEN-1:0] hit_data;
            logic            active;

            // Scan from oldest to youngest so the youngest match is written last.
            always_comb begin
                hit      = 1'b0;
                hit_rdy  = 1'b0;
                hit_data = '0;
                for (int i = NSTG - 1; i >= 0; i--) begin
                    if (stg_valid[i] && stg_wen[i] &&
                        stg_rd[i*AW +: AW] == src_idx[gi*AW +: AW]) begin
                        hit      = 1'b1;
                        hit_rdy  = stg_rdy[i];
                        hit_data = stg_data[i*XLEN +: XLEN];
                    end
                end
            end

            assign active = src_use[gi] && (src_idx[gi*AW +: AW] != '0);
            assign src_fwd[gi] = active && hit && hit_rdy;
            assign src_stall[gi] = active &&
                (hit ? !hit_rdy : (cnt_reg[src_idx[gi*AW +: AW]] != '0));
            assign src_data[gi*XLEN +: XLEN] = src_fwd[gi] ? hit_data : '0;
        end

        for (gi = 0; gi < NREG; gi++) begin : g_busy
            assign busy_map[gi] = (cnt_reg[gi] != '0);
        end
    endgenerate

    logic dest_stall;
    logic issue_ok;
    logic retire_ok;

    // A destination whose counter is full cannot accept another writer.
    assign dest_stall = id_wen && (id_rd != '0) && (cnt_reg[id_rd] == CNT_MAX);
    assign stall      = id_valid && ((|src_stall) || dest_stall);

    assign fwd1_en   = id_valid && src_fwd[0];
    assign fwd2_en   = id_valid && src_fwd[1];
    assign fwd1_data = id_valid ? src_data[0 +: XLEN] : '0;
    assign fwd2_data = id_valid ? src_data[XLEN +: XLEN] : '0;
    assign sb_err    = sb_err_reg;

    // Flush discards every in-flight writer and ignores same-cycle issue/retire.
    assign issue_ok  = id_fire && id_wen && (id_rd != '0) && !stall && !flush;
    assign retire_ok = retire && (retire_rd != '0) && !flush;

    // Next counter values; paired +1/-1 on one register cancel out.
    always_comb begin
        for (int r = 0; r < NREG; r++) begin
            cnt_next[r] = cnt_reg[r];
        end
        sb_err_next = sb_err_reg;
        for (int r = 1; r < NREG; r++) begin
            if (flush) begin
                cnt_next[r] = '0;
            end else begin
                if (issue_ok && id_rd == AW'(r) &&
                    !(retire_ok && retire_rd == AW'(r) && cnt_reg[r] != '0)) begin
                    if (cnt_reg[r] != CNT_MAX) begin
                        cnt_next[r] = cnt_reg[r] + 1'b1;
                    end
                end else if (!(issue_ok && id_rd == AW'(r)) && retire_ok &&
                             retire_rd == AW'(r) && cnt_reg[r] != '0) begin
                    cnt_next[r] = cnt_reg[r] - 1'b1;
                end
            end
        end
        cnt_next[0] = '0;
        // A retire with no matching in-flight writer is a bookkeeping error.
        if (retire_ok && cnt_reg[retire_rd] == '0) begin
            sb_err_next = 1'b1;
        end
    end

    // Counter and sticky error state.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_reg[r] <= '0;
            end
            sb_err_reg <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_reg[r] <= cnt_next[r];
            end
            sb_err_reg <= sb_err_next;
        end
    end

`ifdef YSYX_220053_SB_PERF_EN
    logic [31:0] stall_cnt_reg;

    // Saturating stall cycle counter; cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_reg <= '0;
        end else if (stall && stall_cnt_reg != 32'hFFFF_FFFF) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_reg;
`endif

endmodule
